// File: rtl/alu_ctrl_pkg.sv
//==============================================================================
// alu_ctrl_pkg : shared constants and types for ALU control / mul-div sequencer
// Rev 1.0
//==============================================================================
`default_nettype none

package alu_ctrl_pkg;

  // ALUOp classes driven by the main control unit
  localparam logic [3:0] c_aluop_and   = 4'b0000;
  localparam logic [3:0] c_aluop_or    = 4'b0001;
  localparam logic [3:0] c_aluop_add   = 4'b0011;
  localparam logic [3:0] c_aluop_sub   = 4'b0100;
  localparam logic [3:0] c_aluop_lui   = 4'b0101;
  localparam logic [3:0] c_aluop_rtype = 4'b0111;

  localparam logic [5:0] c_fn_sll   = 6'h00;
  localparam logic [5:0] c_fn_srl   = 6'h02;
  localparam logic [5:0] c_fn_jr    = 6'h08;
  localparam logic [5:0] c_fn_mfhi  = 6'h10;
  localparam logic [5:0] c_fn_mflo  = 6'h12;
  localparam logic [5:0] c_fn_mult  = 6'h18;
  localparam logic [5:0] c_fn_multu = 6'h19;
  localparam logic [5:0] c_fn_div   = 6'h1A;
  localparam logic [5:0] c_fn_divu  = 6'h1B;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25;
  localparam logic [5:0] c_fn_nor   = 6'h27;

  localparam logic [3:0] c_op_and     = 4'b0000;
  localparam logic [3:0] c_op_or      = 4'b0001;
  localparam logic [3:0] c_op_nor     = 4'b0010;
  localparam logic [3:0] c_op_add     = 4'b0011;
  localparam logic [3:0] c_op_sub     = 4'b0100;
  localparam logic [3:0] c_op_lui     = 4'b0101;
  localparam logic [3:0] c_op_srl     = 4'b0111;
  localparam logic [3:0] c_op_sll     = 4'b1000;
  localparam logic [3:0] c_op_jr      = 4'b1001;
  localparam logic [3:0] c_op_mfhi    = 4'b1010;
  localparam logic [3:0] c_op_mflo    = 4'b1011;
  localparam logic [3:0] c_op_nop     = 4'b1100;
  localparam logic [3:0] c_op_invalid = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // MULT/MULTU/DIV/DIVU occupy funct 0x18..0x1B; bit1 = divide, bit0 = unsigned
  function automatic logic is_muldiv(input logic [5:0] fn);
    return fn[5:2] == 4'b0110;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit.sv
//==============================================================================
// mul_div_unit : iterative shift-add multiplier / restoring divider datapath
// Rev 1.0
//==============================================================================
`default_nettype none

module mul_div_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_step,
  input  logic             i_fix,
  output logic             o_last,
  output logic             o_wr,
  output logic             o_dbz,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_dneg;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_a_neg = ~i_op[0] & i_a[WIDTH-1];
  assign w_b_neg = ~i_op[0] & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // Multiply: r_hi is the running partial sum, r_lo the multiplier shifting out
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide: r_hi is the partial remainder, r_lo the dividend turning into quotient
  assign w_div_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
      r_neg  <= 1'b0;
      r_dneg <= 1'b0;
    end else if (i_start) begin
      r_op   <= i_op;
      r_a    <= i_a;
      r_b    <= w_b_mag;
      r_hi   <= '0;
      r_lo   <= w_a_mag;
      r_cnt  <= CW'(WIDTH - 1);
      r_neg  <= w_a_neg ^ w_b_neg;
      r_dneg <= w_a_neg;
    end else if (i_step) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_op[1]) begin
        r_hi <= w_div_diff[WIDTH] ? w_div_sh[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], ~w_div_diff[WIDTH]};
      end else begin
        r_hi <= w_mul_sum[WIDTH:1];
        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo  = r_neg  ? -r_lo : r_lo;
  assign w_rem  = r_dneg ? -r_hi : r_hi;

  assign o_dbz  = r_op[1] & (r_b == '0);
  assign o_last = (r_cnt == '0);
  assign o_wr   = i_fix;

  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (r_op[1]) begin
      if (o_dbz) begin
        o_hi = r_a;
        o_lo = '1;
      end else begin
        o_hi = w_rem;
        o_lo = w_quo;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_control_muldiv.sv
//==============================================================================
// alu_control_muldiv : ALU operation decode, mul/div sequencer FSM and HI/LO
// Rev 1.0
//==============================================================================
`default_nettype none

module alu_control_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       ALUFunction,
  input  logic             valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       ALUOperation,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_t           r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  logic             w_rtype;
  logic             w_accept;
  logic             w_mf;
  logic             w_md_last;
  logic             w_md_wr;
  logic             w_md_dbz;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;

  always_comb begin
    ALUOperation = c_op_invalid;
    case (ALUOp)
      c_aluop_rtype: begin
        case (ALUFunction)
          c_fn_and:  ALUOperation = c_op_and;
          c_fn_or:   ALUOperation = c_op_or;
          c_fn_nor:  ALUOperation = c_op_nor;
          c_fn_add:  ALUOperation = c_op_add;
          c_fn_sub:  ALUOperation = c_op_sub;
          c_fn_srl:  ALUOperation = c_op_srl;
          c_fn_sll:  ALUOperation = c_op_sll;
          c_fn_jr:   ALUOperation = c_op_jr;
          c_fn_mfhi: ALUOperation = c_op_mfhi;
          c_fn_mflo: ALUOperation = c_op_mflo;
          c_fn_mult, c_fn_multu, c_fn_div, c_fn_divu: ALUOperation = c_op_nop;
          default:   ALUOperation = c_op_invalid;
        endcase
      end
      c_aluop_add: ALUOperation = c_op_add;
      c_aluop_or:  ALUOperation = c_op_or;
      c_aluop_and: ALUOperation = c_op_and;
      c_aluop_lui: ALUOperation = c_op_lui;
      c_aluop_sub: ALUOperation = c_op_sub;
      default:     ALUOperation = c_op_invalid;
    endcase
  end

  assign w_rtype  = (ALUOp == c_aluop_rtype);
  assign w_accept = (r_state == ST_IDLE) & valid & w_rtype & is_muldiv(ALUFunction);
  assign w_mf     = valid & w_rtype & ((ALUFunction == c_fn_mfhi) | (ALUFunction == c_fn_mflo));

  assign busy  = (r_state != ST_IDLE);
  assign done  = (r_state == ST_DONE);
  // DONE never stalls so the mul/div instruction retires and MFHI/MFLO see new data
  assign stall = w_accept | (r_state == ST_RUN) | (r_state == ST_SIGN)
               | (w_mf & busy & (r_state != ST_DONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_dbz   <= 1'b0;
          end
        end
        ST_RUN:  if (w_md_last) r_state <= ST_SIGN;
        ST_SIGN: r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_md_wr) begin
        r_hi  <= w_md_hi;
        r_lo  <= w_md_lo;
        r_dbz <= w_md_dbz;
      end
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

  mul_div_unit #(
    .WIDTH (WIDTH)
  ) u_mul_div (
    .clk     (clk),
    .rst_n   (reset),
    .i_start (w_accept),
    .i_op    (ALUFunction[1:0]),
    .i_a     (A),
    .i_b     (B),
    .i_step  (r_state == ST_RUN),
    .i_fix   (r_state == ST_SIGN),
    .o_last  (w_md_last),
    .o_wr    (w_md_wr),
    .o_dbz   (w_md_dbz),
    .o_hi    (w_md_hi),
    .o_lo    (w_md_lo)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_control_muldiv.sv
//==============================================================================
// tb_alu_control_muldiv : directed + random checks against a behavioural model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_alu_control_muldiv;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [3:0]   ALUOp;
  logic [5:0]   ALUFunction;
  logic         valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALUOperation;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  alu_control_muldiv #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .ALUOp        (ALUOp),
    .ALUFunction  (ALUFunction),
    .valid        (valid),
    .A            (A),
    .B            (B),
    .ALUOperation (ALUOperation),
    .stall        (stall),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo),
    .div_by_zero  (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    logic [3:0] exp;
  } dec_t;

  dec_t dec_tbl [20] = '{
    '{4'b0111, 6'h24, 4'b0000}, '{4'b0111, 6'h25, 4'b0001}, '{4'b0111, 6'h27, 4'b0010},
    '{4'b0111, 6'h20, 4'b0011}, '{4'b0111, 6'h22, 4'b0100}, '{4'b0111, 6'h02, 4'b0111},
    '{4'b0111, 6'h00, 4'b1000}, '{4'b0111, 6'h08, 4'b1001}, '{4'b0111, 6'h10, 4'b1010},
    '{4'b0111, 6'h12, 4'b1011}, '{4'b0111, 6'h18, 4'b1100}, '{4'b0111, 6'h1B, 4'b1100},
    '{4'b0111, 6'h21, 4'b1111}, '{4'b0011, 6'h12, 4'b0011}, '{4'b0001, 6'h00, 4'b0001},
    '{4'b0000, 6'h3F, 4'b0000}, '{4'b0101, 6'h18, 4'b0101}, '{4'b0100, 6'h24, 4'b0100},
    '{4'b1111, 6'h20, 4'b1111}, '{4'b0010, 6'h10, 4'b1111}
  };

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-precision integer arithmetic with the architectural corner cases
  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    int sa;
    int sb;
    int q;
    int r;
    case (fn)
      6'h18: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      6'h19: return {32'h0, a} * {32'h0, b};
      6'h1A: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input bit mf_hazard);
    logic [63:0] exp;
    logic [5:0]  mf_fn;
    int          cyc;
    bit          seen;
    exp   = model(fn, a, b);
    mf_fn = 6'h12;
    ALUOp = 4'b0111; ALUFunction = fn; A = a; B = b; valid = 1'b1;
    #1;
    check("stall_accept", {63'h0, stall}, 64'h1);
    check("busy_accept", {63'h0, busy}, 64'h0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      A = $urandom;
      B = $urandom;
      if (cyc == 1) begin
        check("busy_run", {63'h0, busy}, 64'h1);
        check("dbz_cleared", {63'h0, div_by_zero}, 64'h0);
        if (mf_hazard) begin
          mf_fn       = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12;
          ALUFunction = mf_fn;
          #1;
        end
      end
      if (done) seen = 1'b1;
      else check("stall_busy", {63'h0, stall}, 64'h1);
    end
    check("done_cycle", cyc, W + 2);
    check("hi", {32'h0, hi}, {32'h0, exp[63:32]});
    check("lo", {32'h0, lo}, {32'h0, exp[31:0]});
    check("dbz", {63'h0, div_by_zero}, {63'h0, (fn[1] && b == 32'h0)});
    check("stall_done", {63'h0, stall}, 64'h0);
    if (mf_hazard) check("mf_decode", {60'h0, ALUOperation}, (mf_fn == 6'h10) ? 64'hA : 64'hB);
    valid = 1'b0;
    step();
    check("done_pulse", {62'h0, done, busy}, 64'h0);
  endtask

  initial begin
    reset = 1'b0; valid = 1'b0; ALUOp = 4'b0000; ALUFunction = 6'h00; A = '0; B = '0;
    repeat (3) step();
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_flags", {60'h0, busy, done, stall, div_by_zero}, 64'h0);
    check("rst_decode", {60'h0, ALUOperation}, 64'h0);
    reset = 1'b1;
    step();

    foreach (dec_tbl[i]) begin
      ALUOp = dec_tbl[i].op;
      ALUFunction = dec_tbl[i].fn;
      #1;
      check($sformatf("decode_%0d", i), {60'h0, ALUOperation}, {60'h0, dec_tbl[i].exp});
    end
    step();

    run_md(6'h19, 32'hFFFF_FFFF, 32'h2, 1'b0);
    run_md(6'h18, 32'hFFFF_FFFD, 32'h5, 1'b0);
    run_md(6'h1A, 32'hFFFF_FFF9, 32'h2, 1'b0);
    run_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_md(6'h1A, 32'hFFFF_FFF9, 32'h0, 1'b0);
    run_md(6'h1B, 32'h0000_000A, 32'h0, 1'b0);

    // flag must survive idle cycles and an MFHI until a new mul/div is accepted
    ALUOp = 4'b0111; ALUFunction = 6'h10; valid = 1'b1;
    repeat (3) step();
    check("dbz_sticky", {63'h0, div_by_zero}, 64'h1);
    check("mfhi_idle_stall", {63'h0, stall}, 64'h0);
    run_md(6'h18, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
    run_md(6'h19, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    // reset in the middle of RUN
    ALUOp = 4'b0111; ALUFunction = 6'h18; A = 32'h0BAD_F00D; B = 32'h0000_1234; valid = 1'b1;
    repeat (10) step();
    check("busy_before_rst", {63'h0, busy}, 64'h1);
    #2;
    reset = 1'b0;
    valid = 1'b0;
    #1;
    check("midrst_hilo", {hi, lo}, 64'h0);
    check("midrst_flags", {61'h0, busy, done, stall}, 64'h0);
    step();
    reset = 1'b1;
    step();
    run_md(6'h19, 32'h3, 32'h4, 1'b0);

    for (int i = 0; i < 10; i++) begin
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      fn = 6'h18 + 6'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_md(fn, a, b, i[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_control_muldiv.md
# alu_control_muldiv

Parametrised ALU control with an integrated multi-cycle multiply/divide sequencer for the MIPS unicycle core. It decodes `{ALUOp, ALUFunction}` into the 4-bit `ALUOperation` code for single-cycle ALU ops. It also runs MULT/MULTU/DIV/DIVU iteratively into HI/LO registers and stalls the core until the result is ready. It sits between the main control unit/register file and the ALU, and feeds MFHI/MFLO data to the write-back mux.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width; must be even and at least 4.

Ports (one clock; reset is asynchronous and active-low):
- `clk`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Asynchronous, active-low reset.
- `ALUOp`: input, 4 bits. Opcode class from main control.
- `ALUFunction`: input, 6 bits. Instruction funct field.
- `valid`: input, 1 bit. The current instruction is live this cycle.
- `A`, `B`: input, `WIDTH` bits each. rs and rt operands.
- `ALUOperation`: output, 4 bits. Combinational ALU code.
- `stall`: output, 1 bit. Hold the PC and suppress register-file write.
- `busy`: output, 1 bit. Sequencer is not idle.
- `done`: output, 1 bit. One-cycle pulse when HI/LO have been updated.
- `hi`, `lo`: output, `WIDTH` bits each. Architectural HI/LO registers.
- `div_by_zero`: output, 1 bit. Sticky flag, cleared on the next accepted mul/div.

## Operation
- **Decode, R-type (`ALUOp`=0111), by funct:**
  - 0x24 → AND 0000; 0x25 → OR 0001; 0x27 → NOR 0010; 0x20 → ADD 0011; 0x22 → SUB 0100; 0x02 → SRL 0111; 0x00 → SLL 1000; 0x08 → JR 1001.
  - 0x10 → MFHI 1010; 0x12 → MFLO 1011.
  - 0x18/0x19/0x1A/0x1B (MULT/MULTU/DIV/DIVU) → NOP 1100.
- **Decode, other `ALUOp` values:** 0011 → ADD (addi/lw/sw); 0001 → OR; 0000 → AND; 0101 → LUI 0101 (lui/j/jal); 0100 → SUB (beq/bne).
- **Decode default:** 1111 for every unlisted combination. The decode is purely combinational and independent of state.
- **States:** IDLE, RUN, SIGN, DONE.
  - IDLE → RUN when `valid` and funct is one of 0x18–0x1B with `ALUOp`=0111. This is the accept point: |A| and |B| (signed ops) or A and B (unsigned ops) are latched along with the op type, the result sign, and the dividend sign. `div_by_zero` is cleared.
  - RUN: iteration counter runs from `WIDTH-1` down to 0. Each cycle performs one step: shift-add multiply (2·WIDTH product) or restoring divide (quotient and remainder). RUN → SIGN when the counter reaches 0.
  - SIGN: applies sign correction. Product is negated if operand signs differ. Quotient is negated if signs differ; remainder takes the sign of the dividend. HI/LO are written at the end of this cycle. SIGN → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE unconditionally.
- **Divide by zero (B==0, DIV or DIVU):** computation still takes the full latency. Result is lo = all ones, hi = A (original, unsigned view); `div_by_zero` is set at the HI/LO write.
- **Signed overflow (DIV MIN/−1):** lo = MIN, hi = 0. No flag is raised.
- **Stall:** `stall` = (IDLE and accept condition) or RUN or SIGN.
  - MFHI/MFLO with `valid` while `busy` and not in DONE also asserts `stall`.
  - In DONE, `stall`=0 so the mul/div instruction retires. A still-high `valid` in DONE is never re-accepted.
- **Ignored inputs:** `A`/`B` changes after the accept point are ignored.

## Timing
- **Reset values:** state IDLE; `hi`=`lo`=0; `busy`=`done`=`stall`=`div_by_zero`=0. `ALUOperation` follows its inputs.
- **Latency:** accept edge at cycle 0; RUN occupies cycles 1..WIDTH; SIGN is cycle WIDTH+1, with HI/LO visible after its edge; `done` is high in cycle WIDTH+2. For WIDTH=32, `done` is in cycle 34.
- **`busy` and `stall` windows:** `busy` is high from cycle 1 through cycle WIDTH+2 inclusive. `stall` is high from cycle 0 through cycle WIDTH+1.
- **Reset mid-operation:** returns to IDLE immediately, clears HI/LO, and drops `stall`. No partial result is ever written.
- **Back-to-back:** the earliest next accept is the cycle after DONE. MFHI in the DONE cycle reads the new value.

## Structure
- **Package `alu_ctrl_pkg`:**
  - ALUOp class constants.
  - funct constants (including 0x10/0x12/0x18–0x1B).
  - 4-bit `ALUOperation` codes.
  - State enum.
- **Sub-module `mul_div_unit`:** the iterative datapath (operand latches, counter, accumulator, sign fix). It is controlled by the top-level FSM through start/op/step/fix strobes.
- **Top level:** holds the decode, FSM, stall logic and HI/LO registers.

## Test plan
- **Decode sweep:** ALUOp=0111 funct=0x27 → 0010; ALUOp=0100 → 0100; ALUOp=1111 → 1111; funct=0x10 → 1010.
- **MULTU:** A=0xFFFFFFFF, B=2 → `done` in cycle 34, hi=0x00000001, lo=0xFFFFFFFE; `stall` high in cycles 0–33.
- **MULT and DIV:**
  - MULT A=−3, B=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - DIV A=−7, B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **DIVU by zero:** A=10, B=0 → lo=0xFFFFFFFF, hi=0x0000000A, `div_by_zero`=1. The flag stays set until the next MULT is accepted.
- **Reset mid-RUN:** `reset` low at cycle 10 of a MULT → IDLE, hi=lo=0, `stall`=0. A following MULTU 3×4 → lo=12.
- **Hazard:** MFLO with `valid` during RUN → `stall`=1 until DONE, where lo holds the new value.
